// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared types for the lab ALU operand loader: FSM states, opcode
//            width and the N/Z/C/V flag bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4
  } loader_state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Purpose  : Active-low key -> 2-flop synchronizer -> optional debounce
//            counter (LOADER_DEBOUNCE_EN) -> one-cycle press pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_p
);

  logic r_sync1;
  logic r_sync2;
  logic r_db_q;
  logic w_db;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

`ifdef LOADER_DEBOUNCE_EN
  localparam int                CNT_W    = $clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_db;

  // The level flips only after it has differed for DB_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_db  <= 1'b1;
    end else if (r_sync2 == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt >= CNT_LAST) begin
      r_db  <= r_sync2;
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_db = r_db;
`else
  assign w_db = r_sync2;

  if (DB_CYCLES < 1) begin : g_db_cycles_invalid
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_q <= 1'b1;
    end else begin
      r_db_q <= w_db;
    end
  end

  assign press_p = r_db_q & ~w_db;

endmodule

`default_nettype wire

// File: rtl/alu_operand_loader.sv
// ============================================================================
// Module   : alu_operand_loader
// Purpose  : Loads operands A, B and opcode from switches on key presses,
//            strobes execute, captures ALU result/flags. Debounce counters
//            are built only when LOADER_DEBOUNCE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int W         = 4,
  parameter int DB_CYCLES = 500000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    sw,
  input  logic [OP_W-1:0] op_sw,
  input  logic            key_next_n,
  input  logic            key_clr_n,
  input  logic [W-1:0]    op_result_i,
  input  logic            n_i,
  input  logic            z_i,
  input  logic            c_i,
  input  logic            v_i,
  output logic [W-1:0]    a_o,
  output logic [W-1:0]    b_o,
  output logic [OP_W-1:0] op_o,
  output logic            exec_o,
  output logic [W-1:0]    result_o,
  output logic            n_o,
  output logic            z_o,
  output logic            c_o,
  output logic            v_o,
  output logic [2:0]      state_o
);

  loader_state_t r_state;
  loader_state_t w_state_nxt;

  logic w_next_p;
  logic w_clr_p;
  logic w_ld_a;
  logic w_ld_b;
  logic w_ld_op;
  logic w_cap;
  logic w_clr;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [OP_W-1:0] r_op;
  logic [W-1:0]    r_result;
  alu_flags_t      r_flags;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_next_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key_next_n),
    .press_p (w_next_p)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key_clr_n),
    .press_p (w_clr_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD_A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Clear takes priority over next in every state, including S_EXEC.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_a      = 1'b0;
    w_ld_b      = 1'b0;
    w_ld_op     = 1'b0;
    w_cap       = 1'b0;
    w_clr       = 1'b0;
    if (w_clr_p) begin
      w_clr       = 1'b1;
      w_state_nxt = S_LOAD_A;
    end else begin
      case (r_state)
        S_LOAD_A: begin
          if (w_next_p) begin
            w_ld_a      = 1'b1;
            w_state_nxt = S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (w_next_p) begin
            w_ld_b      = 1'b1;
            w_state_nxt = S_LOAD_OP;
          end
        end
        S_LOAD_OP: begin
          if (w_next_p) begin
            w_ld_op     = 1'b1;
            w_state_nxt = S_EXEC;
          end
        end
        S_EXEC: begin
          w_cap       = 1'b1;
          w_state_nxt = S_SHOW;
        end
        S_SHOW: begin
          if (w_next_p) begin
            w_state_nxt = S_LOAD_A;
          end
        end
        default: w_state_nxt = S_LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else if (w_clr) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      if (w_ld_a) begin
        r_a <= sw;
      end
      if (w_ld_b) begin
        r_b <= sw;
      end
      if (w_ld_op) begin
        r_op <= op_sw;
      end
      // ALU inputs are registered, so its outputs are settled during S_EXEC.
      if (w_cap) begin
        r_result <= op_result_i;
        r_flags  <= '{n: n_i, z: z_i, c: c_i, v: v_i};
      end
    end
  end

  assign a_o      = r_a;
  assign b_o      = r_b;
  assign op_o     = r_op;
  assign result_o = r_result;
  assign n_o      = r_flags.n;
  assign z_o      = r_flags.z;
  assign c_o      = r_flags.c;
  assign v_o      = r_flags.v;
  assign exec_o   = (r_state == S_EXEC);
  assign state_o  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
// ============================================================================
// Module   : tb_alu_operand_loader
// Purpose  : Directed bench for alu_operand_loader (W=4, DB_CYCLES=4) with an
//            adder model ALU; expectations adapt to LOADER_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_operand_loader;

  localparam int W    = 4;
  localparam int DB   = 4;
  localparam int HOLD = DB + 8;
`ifdef LOADER_DEBOUNCE_EN
  localparam int LAT  = DB + 3;
  localparam int GLEN = DB - 1;
`else
  localparam int LAT  = 3;
  localparam int GLEN = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sw;
  logic [3:0]   op_sw;
  logic         key_next_n;
  logic         key_clr_n;
  logic [W-1:0] op_result;
  logic         n_i, z_i, c_i, v_i;
  logic [W-1:0] a_o, b_o, result_o;
  logic [3:0]   op_o;
  logic         exec_o, n_o, z_o, c_o, v_o;
  logic [2:0]   state_o;
  logic [W:0]   alu_sum;

  int total;
  int bad;
  int exec_cnt;
  int e0;
  int lat;

  alu_operand_loader #(.W(W), .DB_CYCLES(DB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw          (sw),
    .op_sw       (op_sw),
    .key_next_n  (key_next_n),
    .key_clr_n   (key_clr_n),
    .op_result_i (op_result),
    .n_i         (n_i),
    .z_i         (z_i),
    .c_i         (c_i),
    .v_i         (v_i),
    .a_o         (a_o),
    .b_o         (b_o),
    .op_o        (op_o),
    .exec_o      (exec_o),
    .result_o    (result_o),
    .n_o         (n_o),
    .z_o         (z_o),
    .c_o         (c_o),
    .v_o         (v_o),
    .state_o     (state_o)
  );

  // Model ALU: adds A and B regardless of opcode.
  assign alu_sum   = {1'b0, a_o} + {1'b0, b_o};
  assign op_result = alu_sum[W-1:0];
  assign n_i       = alu_sum[W-1];
  assign z_i       = (alu_sum[W-1:0] == '0);
  assign c_i       = alu_sum[W];
  assign v_i       = (a_o[W-1] == b_o[W-1]) && (alu_sum[W-1] != a_o[W-1]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (exec_o) exec_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic nxt, input logic clr);
    if (nxt) key_next_n = 1'b0;
    if (clr) key_clr_n  = 1'b0;
    repeat (HOLD) @(negedge clk);
    key_next_n = 1'b1;
    key_clr_n  = 1'b1;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, 32'(state_o), 32'd0);
    check({tag, "_regs"}, {16'd0, a_o, b_o, op_o, result_o}, 32'd0);
    check({tag, "_flags"}, {27'd0, n_o, z_o, c_o, v_o, exec_o}, 32'd0);
  endtask

  initial begin
    total = 0; bad = 0; exec_cnt = 0;
    rst_n = 1'b0; sw = '0; op_sw = '0;
    key_next_n = 1'b1; key_clr_n = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_state", 32'(state_o), 32'd0);

    // Clean press, held long: one pulse, A loaded after LAT cycles.
    sw = 4'h5;
    key_next_n = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (a_o == 4'h5 && lat == 0) lat = i;
    end
    check("press_latency", 32'(lat), 32'(LAT));
    check("load_a", 32'(a_o), 32'h5);
    check("held_one_pulse", 32'(state_o), 32'd1);
    key_next_n = 1'b1;
    repeat (HOLD) @(negedge clk);
    check("release_no_pulse", 32'(state_o), 32'd1);
    press(1'b0, 1'b1);
    check("clr_from_b", {29'd0, state_o}, 32'd0);

    // Full sequence 3 + 6.
    sw = 4'h3; press(1'b1, 1'b0);
    sw = 4'h6; press(1'b1, 1'b0);
    op_sw = 4'h2; e0 = exec_cnt; press(1'b1, 1'b0);
    check("exec_one_cycle", 32'(exec_cnt - e0), 32'd1);
    check("ops", {20'd0, a_o, b_o, op_o}, 32'h362);
    check("result", 32'(result_o), 32'h9);
    check("flags", {28'd0, n_o, z_o, c_o, v_o}, 32'b1001);
    check("show_state", 32'(state_o), 32'd4);
    sw = 4'hA; op_sw = 4'hF;
    repeat (5) @(negedge clk);
    check("result_hold", {24'd0, a_o, result_o}, 32'h39);
    press(1'b1, 1'b0);
    check("show_to_load_a", 32'(state_o), 32'd0);
    check("result_hold_load", 32'(result_o), 32'h9);

    // Clear in S_LOAD_OP.
    sw = 4'hF; press(1'b1, 1'b0);
    sw = 4'h1; press(1'b1, 1'b0);
    check("load_op_state", {24'd0, a_o, b_o}, 32'hF1);
    check("load_op_st", 32'(state_o), 32'd2);
    press(1'b0, 1'b1);
    check_zero("clr_op");

    // Short glitch: filtered with debounce, a real press without it.
    sw = 4'hC;
    key_next_n = 1'b0;
    repeat (GLEN) @(negedge clk);
    key_next_n = 1'b1;
    repeat (HOLD) @(negedge clk);
`ifdef LOADER_DEBOUNCE_EN
    check("glitch_state", 32'(state_o), 32'd0);
    check("glitch_a", 32'(a_o), 32'h0);
`else
    check("glitch_state", 32'(state_o), 32'd1);
    check("glitch_a", 32'(a_o), 32'hC);
`endif
    press(1'b0, 1'b1);

    // Simultaneous next and clear in S_LOAD_B.
    sw = 4'h7; press(1'b1, 1'b0);
    check("both_pre_state", 32'(state_o), 32'd1);
    sw = 4'h9; press(1'b1, 1'b1);
    check("both_state", 32'(state_o), 32'd0);
    check("both_regs", {24'd0, a_o, b_o}, 32'h0);

    // Asynchronous reset in S_SHOW (7 + 1 = 8, N and V set).
    sw = 4'h7; press(1'b1, 1'b0);
    sw = 4'h1; press(1'b1, 1'b0);
    op_sw = 4'h5; press(1'b1, 1'b0);
    check("show2_state", 32'(state_o), 32'd4);
    check("show2_res", {24'd0, result_o, n_o, z_o, c_o, v_o}, 32'h89);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_operand_loader.md
# alu_operand_loader

Sequential front end for the lab ALU datapath. Turns one switch bank plus two push-buttons into registered operands A, B and opcode, fires a one-cycle execute strobe, then captures the ALU's combinational result and N/Z/C/V flags for stable display. Sits between the board's switches/keys and the ALU + BCD display chain.

## Interface
- `W`, default 4: operand and result width.
- `DB_CYCLES`, default 500000: cycles a key must hold a new level before it is accepted (10 ms at 50 MHz).
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `sw` in W: operand switches.
- `op_sw` in 4: opcode switches.
- `key_next_n` in 1: "next/enter" push-button, active-low, asynchronous to `clk`.
- `key_clr_n` in 1: "clear" push-button, active-low, asynchronous to `clk`.
- `op_result_i` in W: ALU result.
- `n_i`, `z_i`, `c_i`, `v_i` in 1 each: ALU flags.
- `a_o`, `b_o` out W: registered operands to the ALU.
- `op_o` out 4: registered opcode to the ALU.
- `exec_o` out 1: one-cycle strobe in S_EXEC.
- `result_o` out W: captured result.
- `n_o`, `z_o`, `c_o`, `v_o` out 1 each: captured flags.
- `state_o` out 3: current FSM state encoding, driven to LEDs.

## Operation
- Each key passes through a 2-flop synchronizer, then the debouncer, then a falling-edge detector that produces a one-cycle press pulse (`next_p`, `clr_p`).
- FSM states and encodings: S_LOAD_A=0, S_LOAD_B=1, S_LOAD_OP=2, S_EXEC=3, S_SHOW=4.
- S_LOAD_A, on `next_p`: a_o <= sw, go to S_LOAD_B.
- S_LOAD_B, on `next_p`: b_o <= sw, go to S_LOAD_OP.
- S_LOAD_OP, on `next_p`: op_o <= op_sw, go to S_EXEC.
- S_EXEC lasts exactly one cycle.
  - `exec_o`=1.
  - result_o <= op_result_i and flags <= n_i/z_i/c_i/v_i. The ALU inputs are already registered, so its outputs are valid in this cycle.
  - Then go to S_SHOW.
- S_SHOW holds result_o and the flags. On `next_p`, go to S_LOAD_A.
- a_o, b_o and op_o keep their values until they are overwritten in their own load state. The display shows the live ALU output during loading.
- `clr_p` in any state:
  - a_o, b_o, op_o, result_o and the flags go to 0.
  - The FSM goes to S_LOAD_A.
- Simultaneous `clr_p` and `next_p`: clear wins, and next is discarded.
- `next_p` arriving in S_EXEC is ignored, not queued.
- Pressing and holding a key produces exactly one pulse. Releasing it produces none.

## Timing
- Reset values:
  - State S_LOAD_A.
  - a_o, b_o, op_o, result_o, n_o, z_o, c_o, v_o, exec_o all 0.
  - state_o=0.
  - Debounced key levels 1 (released), synchronizer flops 1, debounce counters 0.
- Debouncer rules:
  - The counter clears whenever the synchronized level equals the debounced level.
  - Otherwise it increments.
  - When the counter reaches DB_CYCLES-1 while the levels still differ, the debounced level flips and the counter clears.
  - A glitch shorter than DB_CYCLES cycles never changes the debounced level.
- Press latency: a clean key low at cycle 0 gives a press pulse high in cycle 2+DB_CYCLES (±1 for input sampling phase).
- A register load occurs on the clock edge ending the pulse cycle. The new value is visible on the outputs the next cycle.
- Counter width is $clog2(DB_CYCLES)+1. The counter saturates and never wraps.
- Reset asserted mid-operation immediately forces the reset values. No press pulse is generated on reset release.

## Configuration
- `LOADER_DEBOUNCE_EN` defined: the debounce counters are built as described above.
- `LOADER_DEBOUNCE_EN` undefined:
  - The debounced level equals the synchronizer output, so press latency is 2 cycles + edge detect.
  - DB_CYCLES is ignored.
  - All FSM behaviour is unchanged.

## Structure
- Shared package `alu_pkg`:
  - `loader_state_t` enum with the encodings above.
  - `OP_W`=4.
  - Flag bundle struct `alu_flags_t` {n,z,c,v}.
- Sub-module `btn_debounce`, instantiated once per key. It contains the synchronizer, the debounce counter (under `LOADER_DEBOUNCE_EN`) and the falling-edge pulse. Parameter: DB_CYCLES. Ports: clk, rst_n, key_n, press_p.

## Test plan
All scenarios use W=4, DB_CYCLES=4, with the macro defined unless stated otherwise.
- Reset, then sw=0x5 and a clean key_next_n press: a_o=0x5 appears about 7 cycles after the press, state_o=1, exactly one pulse while the key is held.
- Full sequence: A=0x3, B=0x6, op_sw=0x2, with a model ALU returning 0x9 and Z=0. Required: exec_o high for exactly 1 cycle, result_o=0x9 latched, state_o=4. result_o holds after sw changes.
- key_next_n glitch low for 3 cycles: no pulse, state unchanged.
- key_clr_n pressed in S_LOAD_OP after A=0xF, B=0x1: all registered outputs 0, state_o=0.
- Both keys pressed in the same cycle while in S_LOAD_B: clear wins, b_o=0, state_o=0.
- Macro undefined: a press produces a pulse 3 cycles after key low, and a 1-cycle glitch produces a pulse. Assert rst_n low during S_SHOW: all outputs 0 immediately.
